clocked_delay_chain: RTL and testbench



---
 rtl/delay_chain_pkg.sv | 33 +++
 rtl/delay_chain_lane.sv | 59 +++++
 rtl/clocked_delay_chain.sv | 178 +++++++++++++++++
 tb/tb_clocked_delay_chain.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/delay_chain_pkg.sv
// Shared types and helpers for the clocked delay chain: FSM/mode encodings,
// LFSR feedback taps and a saturating accumulator.
package delay_chain_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_e;

    typedef enum logic [1:0] {
        MODE_TOGGLE = 2'd0,
        MODE_LFSR   = 2'd1,
        MODE_QUIET  = 2'd2
    } mode_e;

    // x^16+x^14+x^13+x^11+1, right-shifting form: feedback from bits 0,2,3,5
    localparam logic [15:0] LFSR_TAP_MASK = 16'h002D;

    function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
        return {^(cur & LFSR_TAP_MASK), cur[15:1]};
    endfunction

    function automatic logic [63:0] sat_add(input logic [63:0] a,
                                            input logic [63:0] b,
                                            input logic [63:0] max_val);
        logic [64:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return (sum > {1'b0, max_val}) ? max_val : sum[63:0];
    endfunction

endpackage

// File: rtl/delay_chain_lane.sv
// One lane: inject register, STAGES-deep shift register and a tap mux
// selecting which stage is observed.
module delay_chain_lane
    import delay_chain_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned STAGES = 16,
    parameter int unsigned TAP_W  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             load,
    input  logic             invert,
    input  logic [WIDTH-1:0] inject_word,
    input  logic [TAP_W-1:0] tap,
    output logic [WIDTH-1:0] tap_out
);

    logic [WIDTH-1:0] inject_q, inject_d;
    logic [WIDTH-1:0] stage_q [STAGES];
    logic [WIDTH-1:0] stage_d [STAGES];

    always_comb begin
        inject_d = inject_q;
        if (clear) begin
            inject_d = '0;
        end else if (load) begin
            inject_d = invert ? ~inject_q : inject_word;
        end
        stage_d[0] = clear ? '0 : inject_q;
        for (int unsigned i = 1; i < STAGES; i++) begin
            stage_d[i] = clear ? '0 : stage_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inject_q <= '0;
            for (int unsigned i = 0; i < STAGES; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            inject_q <= inject_d;
            stage_q  <= stage_d;
        end
    end

    // Tap values beyond the last stage read as zero.
    always_comb begin
        tap_out = '0;
        for (int unsigned i = 0; i < STAGES; i++) begin
            if (tap == TAP_W'(i)) begin
                tap_out = stage_q[i];
            end
        end
    end

endmodule

// File: rtl/clocked_delay_chain.sv
// Clocked activity generator: CHANNELS register pipelines fed from a
// selectable stimulus, with run control, transition and cycle counters.
module clocked_delay_chain
    import delay_chain_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned STAGES    = 16,
    parameter int unsigned CHANNELS  = 4,
    parameter int unsigned CNT_W     = 32,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [1:0]                    mode,
    input  logic [CNT_W-1:0]              run_cycles,
    input  logic [$clog2(STAGES)-1:0]     tap_sel,
    output logic                          busy,
    output logic                          done,
    output logic [CHANNELS*WIDTH-1:0]     ch_out,
    output logic [CNT_W-1:0]              toggle_count,
    output logic [CNT_W-1:0]              cycle_count
);

    localparam int unsigned TAP_W   = $clog2(STAGES);
    localparam int unsigned DRAIN_W = $clog2(STAGES + 1);
    localparam int unsigned POP_W   = $clog2(CHANNELS * WIDTH + 1);
    localparam logic [63:0] CNT_MAX = 64'({CNT_W{1'b1}});

    state_e                      state_q, state_d;
    mode_e                       mode_q, mode_d;
    logic [TAP_W-1:0]            tap_q, tap_d;
    logic [CNT_W-1:0]            remain_q, remain_d;
    logic [DRAIN_W-1:0]          drain_q, drain_d;
    logic [15:0]                 lfsr_q, lfsr_d;
    logic [CNT_W-1:0]            tog_q, tog_d;
    logic [CNT_W-1:0]            cyc_q, cyc_d;
    logic [CHANNELS*WIDTH-1:0]   ch_prev_q, ch_prev_d;
    logic                        busy_q, busy_d;
    logic                        done_q, done_d;

    logic                        accept;
    logic                        load;
    logic                        in_busy;
    logic [CHANNELS*WIDTH-1:0]   ch_now;
    logic [CHANNELS*WIDTH-1:0]   diff;
    logic [POP_W-1:0]            flips;

    assign accept  = start && (state_q == ST_IDLE || state_q == ST_DONE);
    assign load    = (state_q == ST_RUN);
    assign in_busy = (state_q == ST_RUN) || (state_q == ST_DRAIN);

    for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
        logic [WIDTH-1:0] word;

        always_comb begin
            word = '0;
            if (mode_q == MODE_LFSR) begin
                word = lfsr_q[WIDTH-1:0] ^ WIDTH'(c);
            end
        end

        delay_chain_lane #(
            .WIDTH (WIDTH),
            .STAGES(STAGES),
            .TAP_W (TAP_W)
        ) u_lane (
            .clk        (clk),
            .rst_n      (rst_n),
            .clear      (accept),
            .load       (load),
            .invert     (mode_q == MODE_TOGGLE),
            .inject_word(word),
            .tap        (tap_q),
            .tap_out    (ch_now[c*WIDTH +: WIDTH])
        );
    end

    always_comb begin
        diff  = ch_now ^ ch_prev_q;
        flips = '0;
        for (int unsigned i = 0; i < CHANNELS * WIDTH; i++) begin
            flips = flips + POP_W'(diff[i]);
        end
    end

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        tap_d     = tap_q;
        remain_d  = remain_q;
        drain_d   = drain_q;
        lfsr_d    = lfsr_q;
        tog_d     = tog_q;
        cyc_d     = cyc_q;
        ch_prev_d = ch_prev_q;
        busy_d    = busy_q;
        done_d    = done_q;

        // Counters run on every RUN/DRAIN edge; the DRAIN tail lets the
        // last injected word reach any tap and be counted.
        if (in_busy) begin
            tog_d     = CNT_W'(sat_add(64'(tog_q), 64'(flips), CNT_MAX));
            cyc_d     = CNT_W'(sat_add(64'(cyc_q), 64'd1, CNT_MAX));
            ch_prev_d = ch_now;
        end

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    mode_d    = (mode == 2'd3) ? MODE_QUIET : mode_e'(mode);
                    tap_d     = tap_sel;
                    remain_d  = run_cycles;
                    drain_d   = '0;
                    lfsr_d    = LFSR_SEED;
                    tog_d     = '0;
                    cyc_d     = '0;
                    ch_prev_d = '0;
                    busy_d    = 1'b1;
                    done_d    = 1'b0;
                    state_d   = (run_cycles == '0) ? ST_DRAIN : ST_RUN;
                end
            end
            ST_RUN: begin
                remain_d = remain_q - CNT_W'(1);
                lfsr_d   = lfsr_step(lfsr_q);
                if (remain_q == CNT_W'(1)) begin
                    state_d = ST_DRAIN;
                    drain_d = '0;
                end
            end
            ST_DRAIN: begin
                drain_d = drain_q + DRAIN_W'(1);
                if (drain_q == DRAIN_W'(STAGES)) begin
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            mode_q    <= MODE_TOGGLE;
            tap_q     <= '0;
            remain_q  <= '0;
            drain_q   <= '0;
            lfsr_q    <= LFSR_SEED;
            tog_q     <= '0;
            cyc_q     <= '0;
            ch_prev_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            tap_q     <= tap_d;
            remain_q  <= remain_d;
            drain_q   <= drain_d;
            lfsr_q    <= lfsr_d;
            tog_q     <= tog_d;
            cyc_q     <= cyc_d;
            ch_prev_q <= ch_prev_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign ch_out       = ch_now;
    assign toggle_count = tog_q;
    assign cycle_count  = cyc_q;

endmodule

// File: tb/tb_clocked_delay_chain.sv
// Randomized self-checking bench for clocked_delay_chain against a
// word-sequence reference model; second instance covers counter saturation.
module tb_clocked_delay_chain;

    localparam int W    = 8;
    localparam int S    = 16;
    localparam int C    = 4;
    localparam int CW   = 32;
    localparam int TAPW = $clog2(S);

    typedef logic [C*W-1:0] word_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic            start = 1'b0;
    logic [1:0]      mode = '0;
    logic [CW-1:0]   run_cycles = '0;
    logic [TAPW-1:0] tap_sel = '0;
    logic            busy, done;
    word_t           ch_out;
    logic [CW-1:0]   toggle_count, cycle_count;

    logic            start8 = 1'b0;
    logic [1:0]      mode8 = '0;
    logic [7:0]      rc8 = '0;
    logic [TAPW-1:0] tap8 = '0;
    logic            busy8, done8;
    word_t           ch8;
    logic [7:0]      tog8, cyc8;

    int n_checks = 0;
    int n_fail = 0;

    word_t exp_words[$];

    clocked_delay_chain #(.WIDTH(W), .STAGES(S), .CHANNELS(C), .CNT_W(CW),
                          .LFSR_SEED(16'hACE1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
        .run_cycles(run_cycles), .tap_sel(tap_sel), .busy(busy), .done(done),
        .ch_out(ch_out), .toggle_count(toggle_count), .cycle_count(cycle_count)
    );

    clocked_delay_chain #(.WIDTH(W), .STAGES(S), .CHANNELS(C), .CNT_W(8),
                          .LFSR_SEED(16'hACE1)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .mode(mode8),
        .run_cycles(rc8), .tap_sel(tap8), .busy(busy8), .done(done8),
        .ch_out(ch8), .toggle_count(tog8), .cycle_count(cyc8)
    );

    // Well-known right-shift form of the x^16+x^14+x^13+x^11+1 LFSR.
    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        logic [15:0] b;
        b = (v ^ (v >> 2) ^ (v >> 3) ^ (v >> 5)) & 16'h1;
        return (v >> 1) | (b << 15);
    endfunction

    task automatic gen_words(input logic [1:0] md, input int n);
        logic [15:0] lf;
        word_t cur, w;
        logic [W-1:0] lane, cidx;
        exp_words.delete();
        lf = 16'hACE1;
        cur = '0;
        for (int k = 0; k < n; k++) begin
            for (int c = 0; c < C; c++) begin
                cidx = W'(c);
                case (md)
                    2'd0:    lane = ~cur[c*W +: W];
                    2'd1:    lane = lf[W-1:0] ^ cidx;
                    default: lane = '0;
                endcase
                w[c*W +: W] = lane;
            end
            exp_words.push_back(w);
            cur = w;
            lf = lfsr_next(lf);
        end
    endtask

    // Observed word after busy edge e: word k (1-based) shows after edge k+1+tap.
    function automatic word_t exp_ch(input int e, input int tap, input int n);
        int idx;
        idx = e - 1 - tap;
        if (idx < 1 || n == 0) return '0;
        if (idx > n) return exp_words[n-1];
        return exp_words[idx-1];
    endfunction

    function automatic longint total_flips(input int n);
        longint s;
        word_t p;
        s = 0;
        p = '0;
        for (int k = 0; k < n; k++) begin
            s += $countones(exp_words[k] ^ p);
            p = exp_words[k];
        end
        return s;
    endfunction

    task automatic run_main(input logic [1:0] md, input int rc, input int tap,
                            input int mid_start, input longint tog_const,
                            input string name);
        int total;
        longint acc;
        word_t prev, ech;
        logic [CW-1:0] etog;
        gen_words(md, rc);
        total = rc + S + 1;
        @(negedge clk);
        mode = md; run_cycles = CW'(rc); tap_sel = TAPW'(tap); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || done !== 1'b0 || cycle_count !== '0 || toggle_count !== '0) begin
            n_fail++;
            $display("FAIL %s start: busy=%b done=%b cyc=%0d tog=%0d, required 1 0 0 0",
                     name, busy, done, cycle_count, toggle_count);
        end
        acc = 0;
        prev = '0;
        for (int e = 1; e <= total; e++) begin
            if (e == 1) begin
                mode = 2'($urandom); run_cycles = CW'($urandom_range(0, 200));
                tap_sel = TAPW'($urandom);
            end
            start = (e == mid_start);
            @(negedge clk);
            ech = exp_ch(e, tap, rc);
            etog = CW'(acc);
            n_checks++;
            if (ch_out !== ech) begin
                n_fail++;
                $display("FAIL %s ch_out e=%0d: got %h required %h", name, e, ch_out, ech);
            end
            n_checks++;
            if (cycle_count !== CW'(e) || toggle_count !== etog) begin
                n_fail++;
                $display("FAIL %s counters e=%0d: cyc=%0d tog=%0d required %0d %0d",
                         name, e, cycle_count, toggle_count, e, etog);
            end
            n_checks++;
            if (busy !== (e < total) || done !== (e == total)) begin
                n_fail++;
                $display("FAIL %s flags e=%0d: busy=%b done=%b required %b %b",
                         name, e, busy, done, e < total, e == total);
            end
            acc += $countones(ech ^ prev);
            prev = ech;
        end
        start = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (toggle_count !== CW'(total_flips(rc)) || cycle_count !== CW'(total)
            || done !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s final: tog=%0d cyc=%0d done=%b busy=%b required %0d %0d 1 0",
                     name, toggle_count, cycle_count, done, busy, total_flips(rc), total);
        end
        if (tog_const >= 0) begin
            n_checks++;
            if (toggle_count !== CW'(tog_const)) begin
                n_fail++;
                $display("FAIL %s plan toggles: got %0d required %0d", name, toggle_count, tog_const);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || ch_out !== '0 || toggle_count !== '0
            || cycle_count !== '0) begin
            n_fail++;
            $display("FAIL reset: busy=%b done=%b ch=%h tog=%0d cyc=%0d required all 0",
                     busy, done, ch_out, toggle_count, cycle_count);
        end
        n_checks++;
        if (busy8 !== 1'b0 || done8 !== 1'b0 || ch8 !== '0 || tog8 !== '0 || cyc8 !== '0) begin
            n_fail++;
            $display("FAIL reset8: busy=%b done=%b ch=%h tog=%0d cyc=%0d required all 0",
                     busy8, done8, ch8, tog8, cyc8);
        end
    endtask

    task automatic test_reset_mid_run();
        @(negedge clk);
        mode = 2'd1; run_cycles = 20; tap_sel = 3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        n_checks++;
        if (cycle_count !== 5 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset: cyc=%0d busy=%b required 5 1", cycle_count, busy);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || ch_out !== '0 || toggle_count !== '0
            || cycle_count !== '0) begin
            n_fail++;
            $display("FAIL mid_reset: busy=%b done=%b ch=%h tog=%0d cyc=%0d required all 0",
                     busy, done, ch_out, toggle_count, cycle_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0 || cycle_count !== '0) begin
            n_fail++;
            $display("FAIL post_reset idle: done=%b busy=%b cyc=%0d required 0 0 0",
                     done, busy, cycle_count);
        end
        run_main(2'd0, 10, 15, 0, 320, "after_reset");
    endtask

    task automatic test_saturation();
        int waited;
        @(negedge clk);
        mode8 = 2'd0; rc8 = 8'd20; tap8 = 15; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        waited = 0;
        while (done8 !== 1'b1 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        n_checks++;
        if (done8 !== 1'b1) begin
            n_fail++;
            $display("FAIL sat timeout: done8=%b after %0d cycles, required 1", done8, waited);
        end
        n_checks++;
        if (tog8 !== 8'd255 || cyc8 !== 8'd37) begin
            n_fail++;
            $display("FAIL sat counters: tog=%0d cyc=%0d required 255 37", tog8, cyc8);
        end
    endtask

    task automatic test_random();
        int rc, tp, ms;
        logic [1:0] md;
        for (int i = 0; i < 6; i++) begin
            md = 2'($urandom);
            rc = $urandom_range(0, 40);
            tp = $urandom_range(0, S - 1);
            ms = $urandom_range(1, rc + S);
            run_main(md, rc, tp, ms, -1, "random");
        end
    endtask

    initial begin
        test_reset();
        run_main(2'd0, 10, 15, 0, 320, "toggle_tap15");
        run_main(2'd0, 3, 0, 0, 96, "toggle_tap0");
        run_main(2'd2, 50, 9, 20, 0, "quiet_mid_start");
        run_main(2'd0, 0, 7, 0, 0, "zero_run");
        run_main(2'd1, 25, 5, 0, -1, "lfsr");
        test_reset_mid_run();
        test_saturation();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
